// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detect, START/DATA/PARITY/STOP walk driven by sample_done.
// Optional break detection output is compiled in when RX_BREAK_DET_EN is defined.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               sampled_bit,
  input  logic               sample_done,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               data_samp_en,
  output logic               deser_en,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
`ifdef RX_BREAK_DET_EN
  output logic               break_det,
`endif
  output logic               busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [PRESC_W-1:0] presc_q, presc_nxt, edge_nxt;
  logic               par_en_q, par_en_nxt, par_typ_q, par_typ_nxt;
  logic               acc, acc_nxt, perr, perr_nxt;
  logic               deser_nxt, dv_nxt, pe_nxt, se_nxt;
`ifdef RX_BREAK_DET_EN
  logic               zero_q, zero_nxt, bd_nxt;
`endif

  function automatic logic presc_legal(input logic [PRESC_W-1:0] p);
    return (p == PRESC_W'(4)) || (p == PRESC_W'(8)) ||
           (p == PRESC_W'(16)) || (p == PRESC_W'(32));
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    presc_nxt   = presc_q;
    par_en_nxt  = par_en_q;
    par_typ_nxt = par_typ_q;
    acc_nxt     = acc;
    perr_nxt    = perr;
    deser_nxt   = 1'b0;
    dv_nxt      = 1'b0;
    pe_nxt      = 1'b0;
    se_nxt      = 1'b0;
`ifdef RX_BREAK_DET_EN
    zero_nxt    = zero_q;
    bd_nxt      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!RX_IN && presc_legal(prescale)) begin
          state_nxt   = START;
          presc_nxt   = prescale;
          par_en_nxt  = PAR_EN;
          par_typ_nxt = PAR_TYP;
        end
      end
      START: begin
        if (sample_done) begin
          if (sampled_bit) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
            acc_nxt     = 1'b0;
            perr_nxt    = 1'b0;
`ifdef RX_BREAK_DET_EN
            zero_nxt    = 1'b1;
`endif
          end
        end
      end
      DATA: begin
        if (sample_done) begin
          deser_nxt = 1'b1;
          acc_nxt   = acc ^ sampled_bit;
`ifdef RX_BREAK_DET_EN
          zero_nxt  = zero_q & ~sampled_bit;
`endif
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            state_nxt = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (sample_done) begin
          perr_nxt  = sampled_bit ^ acc ^ par_typ_q;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (sample_done) begin
          se_nxt    = ~sampled_bit;
          pe_nxt    = perr;
          dv_nxt    = sampled_bit & ~perr;
`ifdef RX_BREAK_DET_EN
          bd_nxt    = ~sampled_bit & zero_q;
`endif
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Free-running oversample index; bit boundaries come from sample_done, not from here.
    if (state == IDLE || state_nxt == IDLE) begin
      edge_nxt = '0;
    end else if (edge_cnt == presc_q - PRESC_W'(1)) begin
      edge_nxt = '0;
    end else begin
      edge_nxt = edge_cnt + PRESC_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      acc          <= 1'b0;
      perr         <= 1'b0;
      edge_cnt     <= '0;
      data_samp_en <= 1'b0;
      deser_en     <= 1'b0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
      busy         <= 1'b0;
`ifdef RX_BREAK_DET_EN
      zero_q       <= 1'b0;
      break_det    <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      presc_q      <= presc_nxt;
      par_en_q     <= par_en_nxt;
      par_typ_q    <= par_typ_nxt;
      acc          <= acc_nxt;
      perr         <= perr_nxt;
      edge_cnt     <= edge_nxt;
      data_samp_en <= (state_nxt != IDLE);
      deser_en     <= deser_nxt;
      data_valid   <= dv_nxt;
      par_err      <= pe_nxt;
      stp_err      <= se_nxt;
      busy         <= (state_nxt != IDLE);
`ifdef RX_BREAK_DET_EN
      zero_q       <= zero_nxt;
      break_det    <= bd_nxt;
`endif
    end
  end

endmodule
